// File: rtl/ss_sng_lfsr.sv
// Stochastic number generator: LFSR-vs-value comparator emitting an L-bit unipolar stream,
// one bit every F_sampling+1 clocks. Define SS_SNG_ONECOUNT_EN to add the ONES counter port.
module ss_sng_lfsr #(
    parameter int          N          = 16,
    parameter int          L          = 1024,
    parameter int          F_sampling = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                     CLK,
    input  logic                     INIT,
    input  logic                     LOAD,
    input  logic [N-1:0]             VAL,
    output logic                     BUSY,
    output logic                     OUT,
    output logic                     VALID,
`ifdef SS_SNG_ONECOUNT_EN
    output logic                     DONE,
    output logic [$clog2(L+1)-1:0]   ONES
`else
    output logic                     DONE
`endif
);

    localparam int PW  = (F_sampling > 0) ? $clog2(F_sampling + 1) : 1;
    localparam int BCW = (L > 1) ? $clog2(L) : 1;

    // Feedback taps as a bit mask over the LFSR state (bit k = tap k+1).
    localparam logic [N-1:0] TAP_MASK = (N == 16) ? N'(16'hB400) :
                                        (N == 12) ? N'(12'h829)  :
                                                    N'(8'hB8);
    localparam logic [N-1:0] SEED_T    = SEED[N-1:0];
    localparam logic [N-1:0] SEED_INIT = (SEED_T == '0) ? N'(1) : SEED_T;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [N-1:0]    lfsr_r;
    logic [N-1:0]    vreg_r;
    logic [PW-1:0]   presc_r;
    logic [BCW-1:0]  bitcnt_r;
    logic            busy_r;
    logic            out_r;
    logic            valid_r;
    logic            done_r;
    logic            accept_s;
    logic            tick_s;
    logic            last_s;
    logic            bit_s;

    function automatic logic lfsr_fb(input logic [N-1:0] s);
        return ^(s & TAP_MASK);
    endfunction

    // State register.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (LOAD) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control strobes decoded from state, prescaler and bit counter.
    always_comb begin
        accept_s = (state_r == IDLE) && LOAD;
        tick_s   = (state_r == RUN) && (presc_r == PW'(F_sampling));
        last_s   = tick_s && (bitcnt_r == BCW'(L - 1));
        bit_s    = (lfsr_r <= vreg_r);
    end

    // Datapath and registered outputs; the LFSR only moves on bit ticks.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            lfsr_r   <= SEED_INIT;
            vreg_r   <= '0;
            presc_r  <= '0;
            bitcnt_r <= '0;
            busy_r   <= 1'b0;
            out_r    <= 1'b0;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            valid_r <= tick_s;
            done_r  <= last_s;
            if (accept_s) begin
                vreg_r   <= VAL;
                presc_r  <= '0;
                bitcnt_r <= '0;
                busy_r   <= 1'b1;
            end else if (tick_s) begin
                out_r    <= bit_s;
                lfsr_r   <= {lfsr_r[N-2:0], lfsr_fb(lfsr_r)};
                presc_r  <= '0;
                bitcnt_r <= bitcnt_r + BCW'(1);
                busy_r   <= ~last_s;
            end else if (state_r == RUN) begin
                presc_r  <= presc_r + PW'(1);
            end else begin
                presc_r  <= presc_r;
            end
        end
    end

`ifdef SS_SNG_ONECOUNT_EN
    localparam int OCW = $clog2(L + 1);
    logic [OCW-1:0] ones_r;

    // Ones counter: cleared on accept, saturates at L, holds after DONE.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            ones_r <= '0;
        end else if (accept_s) begin
            ones_r <= '0;
        end else if (tick_s && (ones_r != OCW'(L))) begin
            ones_r <= ones_r + OCW'(bit_s);
        end else begin
            ones_r <= ones_r;
        end
    end

    assign ONES = ones_r;
`endif

    assign BUSY  = busy_r;
    assign OUT   = out_r;
    assign VALID = valid_r;
    assign DONE  = done_r;

endmodule
